// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the sine generator datapath.
// The LUT address space is 4 quarters of N_QUARTER_SAMPLES entries.
package sine_pkg;

  localparam int ADDR_WIDTH        = 9;
  localparam int N_QUARTER_SAMPLES = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } phase_state_t;

endpackage

// File: rtl/tick_divider.sv
// Sample-rate strobe: one-cycle tick every TICK_DIVIDER clocks while enabled.
// Zero latency from count to tick; no backpressure, count clears when enable is low.
module tick_divider #(
  parameter int TICK_DIVIDER = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIVIDER - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/phase_accumulator.sv
// NCO phase accumulator feeding the sine LUT address; FTW updates land at a wrap.
// Address updates 1 cycle after a tick, sample_valid 2 cycles after; ftw_ready low while an FTW is pending.
module phase_accumulator #(
  parameter int                     PHASE_WIDTH  = 24,
  parameter int                     ADDR_WIDTH   = sine_pkg::ADDR_WIDTH,
  parameter int                     TICK_DIVIDER = 12,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_FTW  = PHASE_WIDTH'(24'h000800)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  output logic [ADDR_WIDTH-1:0]  read_address,
  output logic                   sample_valid,
  output logic                   wrap
);

  import sine_pkg::*;

  if (PHASE_WIDTH < ADDR_WIDTH) begin : g_bad_width
    $error("PHASE_WIDTH must be >= ADDR_WIDTH");
  end
  if (TICK_DIVIDER < 2) begin : g_bad_divider
    $error("TICK_DIVIDER must be >= 2");
  end

  phase_state_t           state;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] active_ftw;
  logic [PHASE_WIDTH-1:0] pending_ftw;
  logic [PHASE_WIDTH:0]   sum;
  logic                   carry;
  logic                   tick;
  logic                   tick_en;
  logic                   xfer;
  logic                   retune;
  logic                   tick_d1;

  assign tick_en = enable && (state != IDLE);

  tick_divider #(
    .TICK_DIVIDER (TICK_DIVIDER)
  ) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tick_en),
    .tick   (tick)
  );

  assign sum   = {1'b0, phase} + {1'b0, active_ftw};
  assign carry = sum[PHASE_WIDTH];
  assign xfer  = ftw_valid && ftw_ready;
  // A zero FTW never wraps, so any tick counts as a safe retune point.
  assign retune = tick && (carry || active_ftw == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      active_ftw   <= DEFAULT_FTW;
      pending_ftw  <= '0;
      wrap         <= 1'b0;
      tick_d1      <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      wrap         <= tick && carry;
      tick_d1      <= tick;
      sample_valid <= tick_d1;
      if (tick) begin
        phase <= sum[PHASE_WIDTH-1:0];
      end
      case (state)
        IDLE: begin
          if (xfer) active_ftw <= ftw_in;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            if (xfer) active_ftw <= ftw_in;
            state <= IDLE;
          end else if (xfer) begin
            if (retune) begin
              active_ftw <= ftw_in;
            end else begin
              pending_ftw <= ftw_in;
              state       <= PENDING;
            end
          end
        end
        PENDING: begin
          if (!enable) begin
            active_ftw <= pending_ftw;
            state      <= IDLE;
          end else if (retune) begin
            active_ftw <= pending_ftw;
            state      <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ftw_ready    = (state != PENDING);
  assign read_address = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: tb/tb_phase_accumulator.sv
// Randomized and directed bench for phase_accumulator against a cycle-level arithmetic model.
module tb_phase_accumulator;

  localparam int PW = 24;
  localparam int AW = 9;
  localparam int TD = 4;
  localparam longint MOD = 64'd1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] ftw_in = '0;
  logic          ftw_valid = 1'b0;
  logic          ftw_ready;
  logic [AW-1:0] read_address;
  logic          sample_valid;
  logic          wrap;

  always #5 clk = ~clk;

  phase_accumulator #(
    .PHASE_WIDTH  (PW),
    .ADDR_WIDTH   (AW),
    .TICK_DIVIDER (TD),
    .DEFAULT_FTW  (24'h000800)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ftw_in       (ftw_in),
    .ftw_valid    (ftw_valid),
    .ftw_ready    (ftw_ready),
    .read_address (read_address),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase as an integer, FTW word plus an optional queued word,
  // sample schedule as "cycles since enable, modulo TD".
  longint m_phase, m_ftw, m_pend;
  bit     m_pend_vld, m_run, m_wrap, m_sv1, m_sv;
  int     m_cnt;

  function automatic void model_reset();
    m_phase = 0; m_ftw = 24'h000800; m_pend = 0; m_pend_vld = 0;
    m_run = 0; m_cnt = 0; m_wrap = 0; m_sv1 = 0; m_sv = 0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input longint d);
    bit     tick;
    longint sum;
    bit     carry;
    bit     safe_point;
    bit     accepted;
    tick       = m_run && e && (m_cnt == TD - 1);
    sum        = m_phase + m_ftw;
    carry      = (sum >= MOD);
    safe_point = tick && (carry || m_ftw == 0);
    accepted   = v && !m_pend_vld;
    m_sv  = m_sv1;
    m_sv1 = tick;
    m_wrap = tick && carry;
    if (tick) m_phase = sum % MOD;
    if (!m_run || !e) begin
      if (m_pend_vld) m_ftw = m_pend;
      if (accepted) m_ftw = d;
      m_pend_vld = 0;
    end else if (m_pend_vld) begin
      if (safe_point) begin
        m_ftw = m_pend;
        m_pend_vld = 0;
      end
    end else if (accepted) begin
      if (safe_point) m_ftw = d;
      else begin
        m_pend = d;
        m_pend_vld = 1;
      end
    end
    m_cnt = (m_run && e) ? (m_cnt + 1) % TD : 0;
    m_run = e;
  endfunction

  int wraps_seen = 0;
  int sv_seen = 0;

  task automatic cycle(input bit e, input bit v, input logic [PW-1:0] d);
    @(negedge clk);
    check("addr", 32'(read_address), 32'(m_phase >> (PW - AW)));
    check("ftw_ready", 32'(ftw_ready), 32'(!m_pend_vld));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("sample_valid", 32'(sample_valid), 32'(m_sv));
    wraps_seen += int'(wrap);
    sv_seen += int'(sample_valid);
    enable = e;
    ftw_valid = v;
    ftw_in = d;
    model_step(e, v, longint'(d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    logic [PW-1:0] rd;
    model_reset();
    #12;
    check("rst_addr", 32'(read_address), 32'd0);
    check("rst_ready", 32'(ftw_ready), 32'd1);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady run: one address step per tick, exactly one wrap over a full turn.
    cycle(1'b0, 1'b1, 24'h008000);
    wraps_seen = 0;
    sv_seen = 0;
    repeat (4 * 512 + 8) cycle(1'b1, 1'b0, '0);
    check("steady_wraps", 32'(wraps_seen), 32'd1);
    check("steady_samples", 32'(sv_seen >= 512), 32'd1);

    // Pending update issued at address 100.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_phase >> (PW - AW)) == 100) begin
        found = 1;
        break;
      end
      cycle(1'b1, 1'b0, '0);
    end
    check("reach_addr100", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 24'h010000);
    repeat (2600) cycle(1'b1, 1'b0, '0);

    // New FTW accepted on the very cycle of a wrapping tick.
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_run && m_cnt == TD - 1 && !m_pend_vld && (m_phase + m_ftw) >= MOD) begin
        found = 1;
        break;
      end
      cycle(1'b1, 1'b0, '0);
    end
    check("reach_wrap_tick", 32'(found), 32'd1);
    cycle(1'b1, 1'b1, 24'h008000);
    repeat (40) cycle(1'b1, 1'b0, '0);

    // Enable drop while an FTW is pending.
    cycle(1'b1, 1'b1, 24'h018000);
    repeat (6) cycle(1'b1, 1'b0, '0);
    repeat (8) cycle(1'b0, 1'b0, '0);
    repeat (200) cycle(1'b1, 1'b0, '0);

    // Zero FTW: frozen address, samples still strobe.
    repeat (2) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, '0);
    repeat (3) cycle(1'b0, 1'b0, '0);
    sv_seen = 0;
    repeat (40) cycle(1'b1, 1'b0, '0);
    check("zero_samples", 32'(sv_seen >= 8), 32'd1);
    cycle(1'b1, 1'b1, 24'h008000);
    repeat (40) cycle(1'b1, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rd = '0;
        1: rd = PW'($urandom_range(1, 32'h8000));
        default: rd = PW'($urandom);
      endcase
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, rd);
    end

    // Asynchronous reset mid-run.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(read_address), 32'd0);
    check("arst_ready", 32'(ftw_ready), 32'd1);
    check("arst_sample_valid", 32'(sample_valid), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    model_reset();
    enable = 1'b0;
    ftw_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) cycle(1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
